prm_edge_mask_accum: RTL and testbench
======================================

Name: prm_edge_mask_accum

Overview:
- Downstream consumer of the bank of prm_oblgc_chk* edge checkers.
- Streams 15-bit obstacle voxel codes from the occupancy scanner onto the shared checker input bus (A..O).
- ORs the per-edge edge_mask vector returned by the bank into a blocked-edge bitmap over one scan.
- Dumps the bitmap as 32-bit words, with a running blocked-edge count, to the roadmap graph-search engine.

Parameters:
- N_EDGE, 512: number of edge checkers in the bank; bit i is edge_mask of prm_oblgc_chk<i>. Must be a multiple of 32.
- CODE_W, 15: voxel code width. Bit 0 drives checker input A, bit 14 drives input O.
- NW, N_EDGE/32: number of dump words (derived, not overridable).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- start  in  1  begin a scan. Sampled only in IDLE.
- vox_valid  in  1  voxel code valid.
- vox_ready  out  1  block accepts a voxel.
- vox_code  in  CODE_W  obstacle voxel code.
- vox_last  in  1  final voxel of the scan; qualified by the handshake.
- chk_code  out  CODE_W  registered code driven to all checkers.
- chk_mask  in  N_EDGE  concatenated edge_mask outputs. Combinational from chk_code.
- rd_valid  out  1  dump word valid.
- rd_ready  in  1  consumer accepts the dump word.
- rd_data  out  32  bitmap word; bit j corresponds to edge 32*rd_idx+j.
- rd_idx  out  log2(NW)  word index.
- blocked_cnt  out  log2(N_EDGE)+1  popcount of words already handshaken in this dump.
- vox_cnt  out  16  voxels accepted this scan. Saturates at 0xFFFF.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset: on RST=1 at a clock edge the block does all of the following, regardless of state or in-flight handshakes.
  - State goes to IDLE.
  - Bitmap, chk_code, blocked_cnt, vox_cnt, rd_idx and the pend flag are cleared.
  - vox_ready, rd_valid, busy and done are driven 0.
- State machine: IDLE -> CLR -> SCAN -> DRAIN -> DUMP -> FIN -> IDLE.
- IDLE:
  - start=1 -> CLR.
  - start is ignored in all other states.
- CLR (1 cycle):
  - Bitmap, vox_cnt and blocked_cnt are set to 0; rd_idx is set to 0.
  - -> SCAN.
- SCAN:
  - vox_ready=1 only while no accepted vox_last is outstanding.
  - Accept condition: vox_valid & vox_ready. On accept, chk_code<=vox_code, pend<=1, and vox_cnt is incremented (saturating).
  - On any cycle with pend=1, bitmap <= bitmap | chk_mask (mask sampled the cycle after its code was registered). pend<=0 unless a new voxel is accepted in the same cycle.
  - Throughput is one voxel per cycle. Fold latency is 1 cycle after acceptance.
  - Accept with vox_last=1: vox_ready drops on the next cycle and the state goes to DRAIN.
- DRAIN (1 cycle):
  - Folds the final pending mask, clears pend.
  - -> DUMP.
- DUMP:
  - rd_valid=1; rd_data=bitmap[32*rd_idx +: 32].
  - rd_data and rd_idx are held stable while rd_valid & !rd_ready.
  - On handshake: blocked_cnt += popcount(rd_data).
  - If rd_idx=NW-1 -> FIN; otherwise rd_idx is incremented.
  - Back-to-back handshakes give one word per cycle.
- FIN:
  - done=1 for exactly this one cycle; rd_valid=0.
  - -> IDLE.
  - blocked_cnt, vox_cnt and the bitmap hold until the next CLR.
- Boundary rules:
  - chk_mask is don't-care whenever pend=0, including all of IDLE, CLR and DUMP.
  - Duplicate voxels are idempotent (OR).
  - vox_cnt saturation does not stop acceptance.
  - A scan requires at least one voxel. An unmatched vox_valid holds SCAN indefinitely; RST is the only abort.
  - All 512 edges blocked gives blocked_cnt=512. The width is sized for that value.
  - RST asserted in the same cycle as a voxel accept or a dump handshake: reset wins and the transfer is discarded.

Test Plan:
1. Single voxel: chk_mask model sets only bit 426 for code 0x0A3F. start, one voxel with vox_last -> word 13 = 0x00000400, all other words 0, blocked_cnt=1, vox_cnt=1, done pulses once, 3+NW cycles of busy after the accept with rd_ready=1.
2. Back-to-back stream: 100 voxels with vox_valid held high, model sets bit (code mod 512) -> vox_ready high every SCAN cycle, no fold lost, bitmap equals OR of all 100 masks, vox_cnt=100.
3. Dump backpressure: rd_ready toggled 1,0,0,1,... -> rd_data/rd_idx stable while stalled, words delivered in order 0..15 exactly once, blocked_cnt increments only on handshakes.
4. Full blocking: model returns all-ones -> every word 0xFFFFFFFF, blocked_cnt=512.
5. Reset mid-scan and mid-dump: RST during the 50th voxel, then separately at word 7 -> next cycle state IDLE, all outputs 0, no done pulse. A following clean scan is unaffected by the prior partial bitmap.
6. start ignored while busy; a second scan after FIN with a disjoint mask set -> bitmap contains only the second scan's bits (CLR verified).

Source files
------------

// File: rtl/prm_edge_mask_accum.sv
// Streams obstacle voxel codes to the edge-checker bank and ORs the returned edge masks into a
// blocked-edge bitmap. The bitmap is then dumped as 32-bit words with a running blocked-edge count.
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_CLR   | clear bitmap and counters
//   S_SCAN  | accept voxels, fold the mask of the previous one
//   S_DRAIN | fold the mask of the final voxel
//   S_DUMP  | present bitmap words to the graph-search engine
//   S_FIN   | one-cycle done pulse
module prm_edge_mask_accum #(
  parameter int N_EDGE = 512,
  parameter int CODE_W = 15,
  localparam int NW    = N_EDGE / 32,
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1,
  localparam int CNT_W = $clog2(N_EDGE) + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              vox_valid,
  output logic              vox_ready,
  input  logic [CODE_W-1:0] vox_code,
  input  logic              vox_last,
  output logic [CODE_W-1:0] chk_code,
  input  logic [N_EDGE-1:0] chk_mask,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [31:0]       rd_data,
  output logic [IDX_W-1:0]  rd_idx,
  output logic [CNT_W-1:0]  blocked_cnt,
  output logic [15:0]       vox_cnt,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_SCAN, S_DRAIN, S_DUMP, S_FIN} state_t;

  state_t            r_state, w_next;
  logic [N_EDGE-1:0] r_bitmap;
  logic [CODE_W-1:0] r_code;
  logic              r_pend;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_blocked;
  logic [15:0]       r_vox_cnt;
  logic              w_accept;
  logic              w_rd_hs;
  logic              w_last_word;
  logic [31:0]       w_word;
  logic [CNT_W-1:0]  w_word_ones;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    vox_ready = 1'b0;
    rd_valid  = 1'b0;
    done      = 1'b0;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (start) w_next = S_CLR;
      S_CLR:   w_next = S_SCAN;
      S_SCAN: begin
        vox_ready = 1'b1;
        if (vox_valid && vox_last) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_DUMP;
      S_DUMP: begin
        rd_valid = 1'b1;
        if (rd_ready && w_last_word) w_next = S_FIN;
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept    = vox_ready & vox_valid;
  assign w_rd_hs     = rd_valid & rd_ready;
  assign w_last_word = (r_idx == IDX_W'(NW - 1));
  assign w_word      = r_bitmap[{r_idx, 5'd0} +: 32];

  always_comb begin
    w_word_ones = '0;
    for (int j = 0; j < 32; j++) w_word_ones = w_word_ones + CNT_W'(w_word[j]);
  end

  // The mask for a code arrives one cycle after the code is registered, hence the pend flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bitmap  <= '0;
      r_code    <= '0;
      r_pend    <= 1'b0;
      r_idx     <= '0;
      r_blocked <= '0;
      r_vox_cnt <= '0;
    end else begin
      case (r_state)
        S_CLR: begin
          r_bitmap  <= '0;
          r_vox_cnt <= '0;
          r_blocked <= '0;
          r_idx     <= '0;
          r_pend    <= 1'b0;
        end
        S_SCAN, S_DRAIN: begin
          if (r_pend) r_bitmap <= r_bitmap | chk_mask;
          r_pend <= w_accept;
          if (w_accept) begin
            r_code <= vox_code;
            if (r_vox_cnt != 16'hFFFF) r_vox_cnt <= r_vox_cnt + 16'd1;
          end
        end
        S_DUMP: begin
          if (w_rd_hs) begin
            r_blocked <= r_blocked + w_word_ones;
            if (!w_last_word) r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign chk_code    = r_code;
  assign rd_data     = w_word;
  assign rd_idx      = r_idx;
  assign blocked_cnt = r_blocked;
  assign vox_cnt     = r_vox_cnt;

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// Bench for prm_edge_mask_accum: table vectors, reset/backpressure/restart sequences and
// randomized scans checked against an OR-of-masks bitmap reference.
`timescale 1ns/1ps
module tb_prm_edge_mask_accum;
  localparam int N_EDGE = 512;
  localparam int CODE_W = 15;
  localparam int NW     = N_EDGE / 32;
  localparam int M_SINGLE = 0, M_MOD = 1, M_ALL = 2, M_HASH = 3, M_LO = 4, M_HI = 5;
  localparam int R_ALWAYS = 0, R_PATTERN = 1, R_RANDOM = 2;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              start = 1'b0;
  logic              vox_valid = 1'b0;
  logic              vox_last = 1'b0;
  logic              rd_ready = 1'b0;
  logic [CODE_W-1:0] vox_code = '0;
  logic              vox_ready, rd_valid, busy, done;
  logic [CODE_W-1:0] chk_code;
  logic [N_EDGE-1:0] chk_mask;
  logic [31:0]       rd_data;
  logic [3:0]        rd_idx;
  logic [9:0]        blocked_cnt;
  logic [15:0]       vox_cnt;

  int checks = 0;
  int failures = 0;
  int mask_mode = M_MOD;
  logic [CODE_W-1:0] q_codes[$];
  logic [31:0]       got_words[NW];

  prm_edge_mask_accum #(.N_EDGE(N_EDGE), .CODE_W(CODE_W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .vox_valid(vox_valid), .vox_ready(vox_ready),
    .vox_code(vox_code), .vox_last(vox_last), .chk_code(chk_code), .chk_mask(chk_mask),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_idx(rd_idx),
    .blocked_cnt(blocked_cnt), .vox_cnt(vox_cnt), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  function automatic logic [N_EDGE-1:0] mask_of(input logic [CODE_W-1:0] c, input int mode);
    logic [N_EDGE-1:0] m;
    int ci;
    m  = '0;
    ci = int'(c);
    case (mode)
      M_SINGLE: if (c == 15'h0A3F) m[426] = 1'b1;
      M_MOD:    m[ci % 512] = 1'b1;
      M_ALL:    m = '1;
      M_HASH: begin
        m[ci % 512] = 1'b1;
        m[(ci * 7 + 3) % 512] = 1'b1;
      end
      M_LO:     m[ci % 256] = 1'b1;
      M_HI:     m[256 + ci % 256] = 1'b1;
      default:  m = '0;
    endcase
    return m;
  endfunction

  // Stand-in for the checker bank: combinational from chk_code.
  always_comb chk_mask = mask_of(chk_code, mask_mode);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_vox_ready"}, vox_ready, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_chk_code"}, chk_code, 0);
    chk({tag, "_vox_cnt"}, vox_cnt, 0);
    chk({tag, "_blocked"}, blocked_cnt, 0);
    chk({tag, "_rd_idx"}, rd_idx, 0);
    @(posedge CLK); #1;
    chk({tag, "_done_after"}, done, 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic do_scan(input int rdy_mode, input bit gaps, input int rst_vox,
                         input int rst_word, input bit poke_start);
    int n, idx, guard, k, exp_idx, run_blk, busy_n, miss, exp_blk;
    bit stalled, finished, seen_ready;
    logic [31:0] prev_data;
    logic [3:0]  prev_idx;
    logic [N_EDGE-1:0] exp_map;
    n = q_codes.size();
    exp_map = '0;
    foreach (q_codes[i]) exp_map |= mask_of(q_codes[i], mask_mode);
    exp_blk = $countones(exp_map);
    for (int w = 0; w < NW; w++) got_words[w] = 32'hDEAD_BEEF;
    idx = 0; guard = 0; miss = 0; busy_n = 0; seen_ready = 0;

    start = 1'b1;
    @(posedge CLK); #1;
    start = poke_start;
    chk("start_busy", busy, 1);
    vox_valid = 1'b1;
    vox_code  = q_codes[0];
    vox_last  = (n == 1);
    while (idx < n && guard < 20 * n + 20) begin
      if (vox_ready) seen_ready = 1;
      else if (seen_ready) miss++;
      if (vox_valid && vox_ready) begin
        if (idx == rst_vox) begin
          RST = 1'b1;
          @(posedge CLK); #1;
          RST = 1'b0; vox_valid = 1'b0; vox_last = 1'b0; start = 1'b0;
          check_reset("rst_scan");
          return;
        end
        idx++;
        if (idx == n) busy_n = 1;
      end
      @(posedge CLK); #1;
      guard++;
      if (idx < n) begin
        vox_valid = !gaps || ($urandom_range(0, 2) != 0);
        vox_code  = vox_valid ? q_codes[idx] : CODE_W'($urandom);
        vox_last  = (idx == n - 1);
      end else begin
        vox_valid = 1'b0;
        vox_last  = 1'b0;
      end
    end
    chk("scan_accepts", idx, n);
    chk("ready_gaps", miss, 0);
    chk("ready_drop", vox_ready, 0);
    chk("vox_cnt", vox_cnt, n);

    exp_idx = 0; run_blk = 0; k = 0; stalled = 0; finished = 0; guard = 0;
    prev_data = '0; prev_idx = '0;
    while (!finished && guard < 40 * NW) begin
      if (busy) busy_n++;
      if (done) begin
        finished = 1;
        chk("fin_no_valid", rd_valid, 0);
      end
      if (rd_valid) begin
        chk("rd_idx", rd_idx, exp_idx);
        chk("blk_run", blocked_cnt, run_blk);
        if (stalled) begin
          chk("stall_idx", rd_idx, prev_idx);
          chk("stall_data", rd_data, prev_data);
        end
        case (rdy_mode)
          R_ALWAYS:  rd_ready = 1'b1;
          R_PATTERN: rd_ready = (k % 3 == 0);
          default:   rd_ready = 1'($urandom_range(0, 1));
        endcase
        k++;
        if (poke_start) start = (rd_idx != 4'(NW - 1));
        if (rst_word >= 0 && int'(rd_idx) == rst_word) begin
          rd_ready = 1'b1;
          RST = 1'b1;
          @(posedge CLK); #1;
          RST = 1'b0; rd_ready = 1'b0; start = 1'b0;
          check_reset("rst_dump");
          return;
        end
        if (rd_ready) begin
          got_words[rd_idx] = rd_data;
          run_blk += $countones(rd_data);
          exp_idx++;
          stalled = 0;
        end else begin
          stalled   = 1;
          prev_idx  = rd_idx;
          prev_data = rd_data;
        end
      end else begin
        rd_ready = 1'($urandom_range(0, 1));
      end
      if (!finished) begin
        @(posedge CLK); #1;
        guard++;
      end
    end
    start = 1'b0;
    rd_ready = 1'b0;
    chk("done_seen", finished, 1);
    chk("words_count", exp_idx, NW);
    for (int w = 0; w < NW; w++) chk($sformatf("word%0d", w), got_words[w], exp_map[32*w +: 32]);
    chk("blocked_final", blocked_cnt, exp_blk);
    if (rdy_mode == R_ALWAYS) chk("busy_cycles", busy_n, NW + 3);
    @(posedge CLK); #1;
    chk("idle_after", busy, 0);
    chk("done_once", done, 0);
    chk("vox_cnt_hold", vox_cnt, n);
    chk("blocked_hold", blocked_cnt, exp_blk);
  endtask

  typedef struct {
    logic [CODE_W-1:0] code;
    int                mode;
    int                widx;
    logic [31:0]       wexp;
    int                blk;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{15'h0A3F, M_SINGLE, 13, 32'h0000_0400, 1};
    vecs[1] = '{15'h0A3F, M_MOD,     1, 32'h8000_0000, 1};
    vecs[2] = '{15'h0000, M_MOD,     0, 32'h0000_0001, 1};
    vecs[3] = '{15'h01FF, M_MOD,    15, 32'h8000_0000, 1};
    vecs[4] = '{15'h1234, M_SINGLE,  1, 32'h0000_0000, 0};
    vecs[5] = '{15'h1234, M_MOD,     1, 32'h0010_0000, 1};
    vecs[6] = '{15'h7FFF, M_ALL,     5, 32'hFFFF_FFFF, 512};

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_vox_ready", vox_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_chk_code", chk_code, 0);
    chk("rst_vox_cnt", vox_cnt, 0);
    chk("rst_blocked", blocked_cnt, 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // single-voxel table
    for (int v = 0; v < 7; v++) begin
      mask_mode = vecs[v].mode;
      q_codes.delete();
      q_codes.push_back(vecs[v].code);
      do_scan(R_ALWAYS, 0, -1, -1, 0);
      chk($sformatf("vec%0d_word", v), got_words[vecs[v].widx], vecs[v].wexp);
      chk($sformatf("vec%0d_blk", v), blocked_cnt, vecs[v].blk);
      chk($sformatf("vec%0d_vcnt", v), vox_cnt, 1);
    end

    // back-to-back stream of 100
    mask_mode = M_MOD;
    q_codes.delete();
    for (int i = 0; i < 100; i++) q_codes.push_back(CODE_W'($urandom));
    do_scan(R_ALWAYS, 0, -1, -1, 0);

    // dump backpressure 1,0,0 pattern
    mask_mode = M_HASH;
    q_codes.delete();
    for (int i = 0; i < 30; i++) q_codes.push_back(CODE_W'($urandom));
    do_scan(R_PATTERN, 0, -1, -1, 0);

    // full blocking
    mask_mode = M_ALL;
    q_codes.delete();
    for (int i = 0; i < 5; i++) q_codes.push_back(CODE_W'($urandom));
    do_scan(R_ALWAYS, 0, -1, -1, 0);
    chk("full_blocked", blocked_cnt, 512);

    // reset mid-scan, then clean scan
    mask_mode = M_MOD;
    q_codes.delete();
    for (int i = 0; i < 100; i++) q_codes.push_back(CODE_W'($urandom));
    do_scan(R_ALWAYS, 0, 49, -1, 0);
    mask_mode = M_LO;
    q_codes.delete();
    for (int i = 0; i < 10; i++) q_codes.push_back(CODE_W'($urandom));
    do_scan(R_ALWAYS, 0, -1, -1, 0);

    // reset at dump word 7, then clean scan
    mask_mode = M_HASH;
    q_codes.delete();
    for (int i = 0; i < 40; i++) q_codes.push_back(CODE_W'($urandom));
    do_scan(R_ALWAYS, 0, -1, 7, 0);
    mask_mode = M_HI;
    q_codes.delete();
    for (int i = 0; i < 10; i++) q_codes.push_back(CODE_W'($urandom));
    do_scan(R_ALWAYS, 0, -1, -1, 0);

    // start held while busy, then a second scan on a disjoint edge set
    mask_mode = M_LO;
    q_codes.delete();
    for (int i = 0; i < 20; i++) q_codes.push_back(CODE_W'($urandom));
    do_scan(R_PATTERN, 0, -1, -1, 1);
    mask_mode = M_HI;
    q_codes.delete();
    for (int i = 0; i < 20; i++) q_codes.push_back(CODE_W'($urandom));
    do_scan(R_ALWAYS, 0, -1, -1, 0);

    // randomized scans with valid gaps and random backpressure
    for (int r = 0; r < 6; r++) begin
      mask_mode = M_HASH;
      q_codes.delete();
      for (int i = 0; i < int'($urandom_range(1, 40)); i++) q_codes.push_back(CODE_W'($urandom));
      do_scan(R_RANDOM, 1, -1, -1, (r % 2) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
